// File: rtl/cache_pkg.sv
// Shared cache-subsystem types: arbiter state encoding, owner tag and line geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int unsigned LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_arbiter.sv
// Shares one 256-bit cacheline memory port between the I-cache and D-cache,
// serializing whole-line transactions with round-robin on ties.
module cacheline_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_t state;
    owner_t     last_grant;

    logic                  req_any_c;
    logic                  grant_d_c;
    logic [ADDR_WIDTH-1:0] grant_addr_c;

    // D wins when it is the only requester or when I owned the port last.
    always_comb begin
        req_any_c    = i_read | d_read | d_write;
        grant_d_c    = (d_read | d_write) & (~i_read | (last_grant == OWN_I));
        grant_addr_c = grant_d_c ? d_addr : i_addr;
    end

    // Downstream controls come only from registers latched at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWN_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any_c) begin
                        mem_addr <= grant_addr_c & LINE_MASK;
                        if (grant_d_c) begin
                            state     <= D_BUSY;
                            mem_read  <= d_read;
                            mem_write <= d_write;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= I_BUSY;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state      <= IDLE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= (state == D_BUSY) ? OWN_D : OWN_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response path is pure pass-through; a transaction cut by reset never completes.
    assign i_resp  = (state == I_BUSY) & mem_resp & ~rst;
    assign d_resp  = (state == D_BUSY) & mem_resp & ~rst;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    d_excl_a: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
    req_known_a: assert property (@(posedge clk) disable iff (rst) !$isunknown({i_read, d_read, d_write}));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter with a delayed line memory that flags protocol errors.
module tb_cacheline_arbiter;

    localparam int DELAY = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    cacheline_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers DELAY cycles after a request starts, flags protocol violations.
    logic [255:0] mem [logic [31:0]];
    bit           mem_err = 1'b0;
    bit           busy = 1'b0;
    int           cnt = 0;
    bit           l_rd, l_wr;
    logic [31:0]  l_addr;
    logic [255:0] l_wdata;

    function automatic logic [255:0] default_line(input logic [31:0] a);
        if (a == 32'h0000_1040) return {8{32'hC0DE_1040}};
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            cnt = 0;
            mem_resp = 1'b0;
        end else if (mem_resp) begin
            mem_resp = 1'b0;
            busy = 1'b0;
            if (mem_read || mem_write) mem_err = 1'b1;
        end else if (mem_read || mem_write) begin
            if (mem_read && mem_write) mem_err = 1'b1;
            if (mem_addr[4:0] != 5'd0) mem_err = 1'b1;
            if (!busy) begin
                busy = 1'b1;
                cnt = 1;
                l_rd = mem_read;
                l_wr = mem_write;
                l_addr = mem_addr;
                l_wdata = mem_wdata;
            end else begin
                if (l_rd != mem_read || l_wr != mem_write || l_addr != mem_addr || l_wdata != mem_wdata)
                    mem_err = 1'b1;
                cnt = cnt + 1;
            end
            if (cnt == DELAY) begin
                mem_resp = 1'b1;
                if (mem_read) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : default_line(mem_addr);
                else mem[mem_addr] = mem_wdata;
            end
        end else if (busy) begin
            mem_err = 1'b1;
        end
    end

    // Transaction log: start of each downstream transaction and every response cycle.
    typedef struct {
        int           cyc;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } start_t;
    typedef struct {
        int cyc;
        bit i;
        bit d;
        bit m;
    } resp_t;

    start_t starts[$];
    resp_t  resps[$];
    bit     prev_act = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_act = 1'b0;
        end else begin
            if ((mem_read || mem_write) && !prev_act)
                starts.push_back('{cyc, mem_read, mem_write, mem_addr, mem_wdata});
            prev_act = mem_read || mem_write;
            if (mem_resp || i_resp || d_resp)
                resps.push_back('{cyc, i_resp, d_resp, mem_resp});
        end
    end

    // Requester agents: called just after a rising edge; raise, wait for resp, release next cycle.
    task automatic do_i(input logic [31:0] addr, output logic [255:0] data,
                        output int req_cyc, output bit to);
        i_addr = addr;
        i_read = 1'b1;
        req_cyc = cyc;
        to = 1'b1;
        data = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (i_resp === 1'b1) begin
                data = i_rdata;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic do_d(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                        output logic [255:0] data, output bit to);
        d_addr = addr;
        d_wdata = wdata;
        d_read = !wr;
        d_write = wr;
        to = 1'b1;
        data = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (d_resp === 1'b1) begin
                data = d_rdata;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        d_read = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 256'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_checks++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL reset_i_resp got %b want 0", i_resp); end
        n_checks++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL reset_d_resp got %b want 0", d_resp); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_i_read();
        logic [255:0] data;
        int qcyc;
        bit to;
        starts.delete(); resps.delete();
        do_i(32'h0000_1040, data, qcyc, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ird_timeout got %b want 0", to); end
        n_checks++; if (data !== {8{32'hC0DE_1040}}) begin n_fail++; $display("FAIL ird_data got %h want %h", data, {8{32'hC0DE_1040}}); end
        n_checks++; if (starts.size() !== 1) begin n_fail++; $display("FAIL ird_txn_count got %0d want 1", starts.size()); end
        n_checks++; if ({starts[0].rd, starts[0].wr} !== 2'b10) begin n_fail++; $display("FAIL ird_cmd got %b want 10", {starts[0].rd, starts[0].wr}); end
        n_checks++; if (starts[0].addr !== 32'h0000_1040) begin n_fail++; $display("FAIL ird_addr got %h want 00001040", starts[0].addr); end
        n_checks++; if (starts[0].cyc - qcyc !== 1) begin n_fail++; $display("FAIL ird_grant_latency got %0d want 1", starts[0].cyc - qcyc); end
        n_checks++; if (resps.size() !== 1 || {resps[0].i, resps[0].d, resps[0].m} !== 3'b101) begin
            n_fail++; $display("FAIL ird_resp_map got n=%0d i=%b d=%b m=%b want n=1 i=1 d=0 m=1", resps.size(), resps[0].i, resps[0].d, resps[0].m); end
        n_checks++; if (resps[0].cyc - starts[0].cyc !== DELAY - 1) begin n_fail++; $display("FAIL ird_resp_cycle got %0d want %0d", resps[0].cyc - starts[0].cyc, DELAY - 1); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL ird_mem_err got %b want 0", mem_err); end
    endtask

    task automatic test_d_write_then_read();
        logic [255:0] data;
        logic [255:0] a5;
        int qcyc;
        bit to_d, to_i;
        a5 = {32{8'hA5}};
        starts.delete(); resps.delete();
        do_d(1'b1, 32'h0000_2000, a5, data, to_d);
        do_i(32'h0000_2000, data, qcyc, to_i);
        n_checks++; if ({to_d, to_i} !== 2'b00) begin n_fail++; $display("FAIL dwr_timeout got %b want 00", {to_d, to_i}); end
        n_checks++; if ({starts[0].rd, starts[0].wr} !== 2'b01) begin n_fail++; $display("FAIL dwr_cmd got %b want 01", {starts[0].rd, starts[0].wr}); end
        n_checks++; if (starts[0].wdata !== a5) begin n_fail++; $display("FAIL dwr_wdata got %h want %h", starts[0].wdata, a5); end
        n_checks++; if (starts[0].addr !== 32'h0000_2000) begin n_fail++; $display("FAIL dwr_addr got %h want 00002000", starts[0].addr); end
        n_checks++; if (data !== a5) begin n_fail++; $display("FAIL dwr_readback got %h want %h", data, a5); end
        n_checks++; if ({resps[0].d, resps[1].i} !== 2'b11) begin n_fail++; $display("FAIL dwr_resp_owner got %b want 11", {resps[0].d, resps[1].i}); end
        n_checks++; if (starts[1].cyc - resps[0].cyc !== 2) begin n_fail++; $display("FAIL dwr_gap got %0d want 2", starts[1].cyc - resps[0].cyc); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL dwr_mem_err got %b want 0", mem_err); end
    endtask

    task automatic test_tie();
        logic [255:0] di, dd, w2;
        int qcyc;
        bit to_i, to_d;
        w2 = {8{32'h1234_5678}};
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        starts.delete(); resps.delete();
        fork
            do_i(32'h0000_4000, di, qcyc, to_i);
            do_d(1'b0, 32'h0000_5000, '0, dd, to_d);
        join
        n_checks++; if ({to_i, to_d} !== 2'b00) begin n_fail++; $display("FAIL tie1_timeout got %b want 00", {to_i, to_d}); end
        n_checks++; if (starts[0].addr !== 32'h0000_5000) begin n_fail++; $display("FAIL tie1_first_owner got addr %h want 00005000 (D)", starts[0].addr); end
        n_checks++; if (starts[1].addr !== 32'h0000_4000) begin n_fail++; $display("FAIL tie1_second_owner got addr %h want 00004000 (I)", starts[1].addr); end
        n_checks++; if (starts[1].cyc - resps[0].cyc !== 2) begin n_fail++; $display("FAIL tie1_gap got %0d want 2", starts[1].cyc - resps[0].cyc); end
        n_checks++; if ({resps[0].d, resps[0].i, resps[1].i, resps[1].d} !== 4'b1010) begin
            n_fail++; $display("FAIL tie1_resp_owner got %b want 1010", {resps[0].d, resps[0].i, resps[1].i, resps[1].d}); end
        n_checks++; if (dd !== default_line(32'h0000_5000)) begin n_fail++; $display("FAIL tie1_d_data got %h want %h", dd, default_line(32'h0000_5000)); end
        n_checks++; if (di !== default_line(32'h0000_4000)) begin n_fail++; $display("FAIL tie1_i_data got %h want %h", di, default_line(32'h0000_4000)); end
        // A lone D write leaves D as last owner, so the next tie goes to I.
        do_d(1'b1, 32'h0000_5000, w2, dd, to_d);
        starts.delete(); resps.delete();
        fork
            do_i(32'h0000_5000, di, qcyc, to_i);
            do_d(1'b0, 32'h0000_4000, '0, dd, to_d);
        join
        n_checks++; if (starts[0].addr !== 32'h0000_5000) begin n_fail++; $display("FAIL tie2_first_owner got addr %h want 00005000 (I)", starts[0].addr); end
        n_checks++; if ({resps[0].i, resps[1].d} !== 2'b11) begin n_fail++; $display("FAIL tie2_resp_owner got %b want 11", {resps[0].i, resps[1].d}); end
        n_checks++; if (di !== w2) begin n_fail++; $display("FAIL tie2_i_data got %h want %h", di, w2); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL tie_mem_err got %b want 0", mem_err); end
    endtask

    task automatic test_unaligned();
        logic [255:0] dd;
        bit to;
        starts.delete(); resps.delete();
        do_d(1'b0, 32'h0000_301C, '0, dd, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL unal_timeout got %b want 0", to); end
        n_checks++; if (starts[0].addr !== 32'h0000_3000) begin n_fail++; $display("FAIL unal_addr got %h want 00003000", starts[0].addr); end
        n_checks++; if (dd !== default_line(32'h0000_3000)) begin n_fail++; $display("FAIL unal_data got %h want %h", dd, default_line(32'h0000_3000)); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL unal_mem_err got %b want 0", mem_err); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] data;
        int qcyc, nresp;
        bit to;
        starts.delete(); resps.delete();
        d_addr = 32'h0000_8000;
        d_read = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got mem_read=%b want 1", mem_read); end
        rst = 1'b1;
        d_read = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL rmid_ctrl got %b want 00", {mem_read, mem_write}); end
        rst = 1'b0;
        nresp = 0;
        repeat (15) begin
            @(negedge clk); #1;
            if (d_resp !== 1'b0 || i_resp !== 1'b0) nresp++;
        end
        n_checks++; if (nresp !== 0) begin n_fail++; $display("FAIL rmid_no_resp got %0d resp cycles want 0", nresp); end
        @(posedge clk); #1;
        do_i(32'h0000_1040, data, qcyc, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_fresh_timeout got %b want 0", to); end
        n_checks++; if (data !== {8{32'hC0DE_1040}}) begin n_fail++; $display("FAIL rmid_fresh_data got %h want %h", data, {8{32'hC0DE_1040}}); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_err got %b want 0", mem_err); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] di, dd, w3;
        int qcyc;
        bit to_i, to_d1, to_d2;
        w3 = {16{16'hBEEF}};
        starts.delete(); resps.delete();
        fork
            do_i(32'h0000_6000, di, qcyc, to_i);
            begin
                do_d(1'b1, 32'h0000_7000, w3, dd, to_d1);
                do_d(1'b0, 32'h0000_7000, '0, dd, to_d2);
            end
        join
        n_checks++; if ({to_i, to_d1, to_d2} !== 3'b000) begin n_fail++; $display("FAIL b2b_timeout got %b want 000", {to_i, to_d1, to_d2}); end
        n_checks++; if (starts.size() !== 3) begin n_fail++; $display("FAIL b2b_txn_count got %0d want 3", starts.size()); end
        n_checks++; if ({starts[0].wr, starts[1].rd, starts[2].rd} !== 3'b111) begin
            n_fail++; $display("FAIL b2b_cmds got %b want 111", {starts[0].wr, starts[1].rd, starts[2].rd}); end
        n_checks++; if ({starts[0].addr, starts[1].addr, starts[2].addr} !== {32'h0000_7000, 32'h0000_6000, 32'h0000_7000}) begin
            n_fail++; $display("FAIL b2b_order got %h %h %h want 00007000 00006000 00007000", starts[0].addr, starts[1].addr, starts[2].addr); end
        n_checks++; if ({resps[0].d, resps[0].i, resps[1].i, resps[1].d, resps[2].d, resps[2].i} !== 6'b101010) begin
            n_fail++; $display("FAIL b2b_resp_owner got %b want 101010", {resps[0].d, resps[0].i, resps[1].i, resps[1].d, resps[2].d, resps[2].i}); end
        n_checks++; if ({resps[0].m, resps[1].m, resps[2].m} !== 3'b111 || resps.size() !== 3) begin
            n_fail++; $display("FAIL b2b_resp_count got n=%0d want 3 mem_resp-aligned", resps.size()); end
        n_checks++; if (starts[1].cyc - resps[0].cyc !== 2 || starts[2].cyc - resps[1].cyc !== 2) begin
            n_fail++; $display("FAIL b2b_gap got %0d,%0d want 2,2", starts[1].cyc - resps[0].cyc, starts[2].cyc - resps[1].cyc); end
        n_checks++; if (dd !== w3) begin n_fail++; $display("FAIL b2b_d_data got %h want %h", dd, w3); end
        n_checks++; if (di !== default_line(32'h0000_6000)) begin n_fail++; $display("FAIL b2b_i_data got %h want %h", di, default_line(32'h0000_6000)); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_err got %b want 0", mem_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_i_read();
        test_d_write_then_read();
        test_tie();
        test_unaligned();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
